// File: rtl/jstk_poller.sv
// jstk_poller: periodic request sequencer and frame decoder for the PmodJSTK
// SPI block. Each poll pulses sndRec with an LED command frame, waits for
// the 5-byte transfer, then checks and decodes the returned 40-bit frame into
// X/Y positions, buttons and dead-zoned direction flags.
module jstk_poller #(
   parameter int POLL_CYCLES = 600000,
   parameter int REQ_CYCLES  = 1200,
   parameter int WAIT_CYCLES = 24000,
   parameter int DEADZONE    = 64
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EN,
   input  logic [1:0]  LED_CMD,
   input  logic [39:0] DOUT,
   output logic        sndRec,
   output logic [39:0] DIN,
   output logic [9:0]  X,
   output logic [9:0]  Y,
   output logic [2:0]  BTN,
   output logic [3:0]  DIR,
   output logic        VALID,
   output logic        FRAME_ERR
);

   localparam int PW   = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
   localparam int CMAX = (REQ_CYCLES > WAIT_CYCLES) ? REQ_CYCLES : WAIT_CYCLES;
   localparam int SW   = (CMAX > 2) ? $clog2(CMAX) : 1;

   localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_CYCLES - 1);
   localparam logic [SW-1:0] REQ_LAST    = SW'(REQ_CYCLES - 1);
   localparam logic [SW-1:0] WAIT_LAST   = SW'(WAIT_CYCLES - 1);

   // Dead-zone edges around mid-scale; values equal to an edge count as centred.
   localparam logic [9:0] DZ_LO = 10'(512 - DEADZONE);
   localparam logic [9:0] DZ_HI = 10'(512 + DEADZONE);

   localparam logic [39:0] DIN_RESET = 40'h80_0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_LATCH = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] period_q, period_d;
   logic [39:0]   din_q, din_d;
   logic          sndrec_q, sndrec_d;
   logic          tick;

   logic [9:0]    x_q, y_q;
   logic [2:0]    btn_q;
   logic [3:0]    dir_q;
   logic          valid_q, ferr_q;

   // Frame fields and checks, only consumed while in LATCH.
   logic [9:0]    x_new, y_new;
   logic [3:0]    dir_new;
   logic          frame_bad;

   assign x_new     = {DOUT[25:24], DOUT[39:32]};
   assign y_new     = {DOUT[9:8],   DOUT[23:16]};
   assign frame_bad = (|DOUT[31:26]) | (|DOUT[15:10]) | (|DOUT[7:3]);
   assign dir_new   = {(y_new > DZ_HI), (y_new < DZ_LO),
                       (x_new > DZ_HI), (x_new < DZ_LO)};

   // Free-running poll period counter; tick marks its last count.
   assign tick     = (period_q == PERIOD_LAST);
   assign period_d = tick ? '0 : period_q + PW'(1);

   // NOTE: async reset in the sensitivity list so sndRec and the decoded
   // outputs clear immediately, without waiting for a clock edge.
   // Period counter register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         period_q <= '0;
      end else begin
         // NOTE: non-blocking assignments for all clocked state so every
         // register samples pre-edge values regardless of statement order.
         period_q <= period_d;
      end
   end

   // Next-state logic: sequence IDLE -> REQ -> WAIT -> LATCH, load command on poll start.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the case leaves one unassigned and infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      din_d   = din_q;
      unique case (state_q)
         S_IDLE: begin
            if (tick && EN) begin
               state_d = S_REQ;
               cnt_d   = '0;
               din_d   = {6'b100000, LED_CMD, 32'h0};
            end
         end
         S_REQ: begin
            if (cnt_q == REQ_LAST) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + SW'(1);
            end
         end
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = S_LATCH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + SW'(1);
            end
         end
         S_LATCH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      // sndRec is registered from the next state so it is high exactly while in REQ.
      sndrec_d = (state_d == S_REQ);
   end

   // FSM state, state counter, command frame and sndRec registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         din_q    <= DIN_RESET;
         sndrec_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         din_q    <= din_d;
         sndrec_q <= sndrec_d;
      end
   end

   // Decoded outputs: update on a clean frame, otherwise hold and flag the error.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         x_q     <= '0;
         y_q     <= '0;
         btn_q   <= '0;
         dir_q   <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         if (state_q == S_LATCH) begin
            if (frame_bad) begin
               ferr_q <= 1'b1;
            end else begin
               x_q     <= x_new;
               y_q     <= y_new;
               btn_q   <= DOUT[2:0];
               dir_q   <= dir_new;
               valid_q <= 1'b1;
            end
         end
      end
   end

   assign sndRec    = sndrec_q;
   assign DIN       = din_q;
   assign X         = x_q;
   assign Y         = y_q;
   assign BTN       = btn_q;
   assign DIR       = dir_q;
   assign VALID     = valid_q;
   assign FRAME_ERR = ferr_q;

endmodule
